// File: rtl/aritmetica_pkg.sv
// ---------------------------------------------------------------------------
// aritmetica_pkg : shared word format defaults and range limits for the MAC
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package aritmetica_pkg;

  localparam int N_DEF = 25;
  localparam int F_DEF = 10;

  localparam logic signed [N_DEF-1:0] MAX_POS = {1'b0, {(N_DEF-1){1'b1}}};
  localparam logic signed [N_DEF-1:0] MAX_NEG = {1'b1, {(N_DEF-1){1'b0}}};

endpackage

`default_nettype wire

// File: rtl/aritmetica_if.sv
// ---------------------------------------------------------------------------
// aritmetica_if : operand/result bundle of the MAC (master = source, slave = MAC)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface aritmetica_if import aritmetica_pkg::*; #(
  parameter int N = N_DEF
) ();

  logic                in_valid;
  logic signed [N-1:0] Constantes_G;
  logic signed [N-1:0] Multip_G;
  logic signed [N-1:0] Entrada_G;
  logic                out_valid;
  logic signed [N-1:0] Valores;

  modport master (
    output in_valid, Constantes_G, Multip_G, Entrada_G,
    input  out_valid, Valores
  );

  modport slave (
    input  in_valid, Constantes_G, Multip_G, Entrada_G,
    output out_valid, Valores
  );

endinterface

`default_nettype wire

// File: rtl/aritmetica_mac_fx_sat.sv
// ---------------------------------------------------------------------------
// fx_sat : reduces a 2N+1-bit sum to N bits; clamps when ARITMETICA_SAT_EN
//          is defined, otherwise keeps the low N bits (wrap)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fx_sat import aritmetica_pkg::*; #(
  parameter int N = N_DEF
) (
  input  logic signed [2*N:0] din,
  output logic signed [N-1:0] dout
);

`ifdef ARITMETICA_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic signed [N-1:0] C_MAX_POS = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] C_MAX_NEG = {1'b1, {(N-1){1'b0}}};
  localparam logic signed [2*N:0] C_HI      = {{(N+1){1'b0}}, C_MAX_POS};
  localparam logic signed [2*N:0] C_LO      = {{(N+1){1'b1}}, C_MAX_NEG};

  logic ovf_hi;
  logic ovf_lo;

  always_comb begin
    ovf_hi = (din > C_HI);
    ovf_lo = (din < C_LO);
    dout   = din[N-1:0];
    if (SAT_EN && ovf_hi) begin
      dout = C_MAX_POS;
    end else if (SAT_EN && ovf_lo) begin
      dout = C_MAX_NEG;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aritmetica_mac.sv
// ---------------------------------------------------------------------------
// aritmetica_mac : two-stage fixed-point MAC, Valores = (C*M >>> F) + E
//                  overflow mode selected by ARITMETICA_SAT_EN (see fx_sat)
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module aritmetica_mac import aritmetica_pkg::*; #(
  parameter int N = N_DEF,
  parameter int F = F_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  aritmetica_if.slave bus
);

  logic                  v1_q, v1_d;
  logic                  v2_q, v2_d;
  logic signed [2*N-1:0] prod_q, prod_d;
  logic signed [N-1:0]   add_q, add_d;
  logic signed [N-1:0]   valores_q, valores_d;

  logic signed [2*N-1:0] c_ext;
  logic signed [2*N-1:0] m_ext;
  logic signed [2*N-1:0] shifted;
  logic signed [2*N:0]   sum;
  logic signed [N-1:0]   reduced;

  // Stage 1: operands sign-extended so the low 2N bits hold the exact product
  always_comb begin
    c_ext  = {{N{bus.Constantes_G[N-1]}}, bus.Constantes_G};
    m_ext  = {{N{bus.Multip_G[N-1]}}, bus.Multip_G};
    v1_d   = bus.in_valid;
    prod_d = prod_q;
    add_d  = add_q;
    if (bus.in_valid) begin
      prod_d = c_ext * m_ext;
      add_d  = bus.Entrada_G;
    end
  end

  // Stage 2 datapath: floor shift, then a sum one bit wider than the product
  always_comb begin
    shifted = prod_q >>> F;
    sum     = {shifted[2*N-1], shifted} + {{(N+1){add_q[N-1]}}, add_q};
  end

  fx_sat #(.N(N)) u_fx_sat (
    .din  (sum),
    .dout (reduced)
  );

  always_comb begin
    v2_d      = v1_q;
    valores_d = v1_q ? reduced : valores_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      prod_q    <= '0;
      add_q     <= '0;
      valores_q <= '0;
    end else begin
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      prod_q    <= prod_d;
      add_q     <= add_d;
      valores_q <= valores_d;
    end
  end

  assign bus.out_valid = v2_q;
  assign bus.Valores   = valores_q;

endmodule

`default_nettype wire

// File: tb/tb_aritmetica_mac.sv
// ---------------------------------------------------------------------------
// tb_aritmetica_mac : directed and random checks of aritmetica_mac against
//                     an arithmetic reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_aritmetica_mac;
  import aritmetica_pkg::*;

  localparam int N = N_DEF;
  localparam int F = F_DEF;

  typedef struct {
    bit           v;
    logic [N-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  exp_t hist[$];
  logic [N-1:0] hold;

  always #5 clk = ~clk;

  aritmetica_if #(.N(N)) bus ();

  aritmetica_mac #(.N(N), .F(F)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [N-1:0] model(input longint c, input longint m, input longint e);
    longint s;
    s = ((c * m) >>> F) + e;
`ifdef ARITMETICA_SAT_EN
    if (s > longint'(MAX_POS)) s = longint'(MAX_POS);
    else if (s < longint'(MAX_NEG)) s = longint'(MAX_NEG);
`endif
    return s[N-1:0];
  endfunction

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_t z;
    z.v   = 1'b0;
    z.val = '0;
    hist  = {};
    hist.push_back(z);
    hist.push_back(z);
    hold  = '0;
  endtask

  // One clock: drive at negedge, record what the DUT samples, check 1ns after the edge
  task automatic cycle(input bit v, input logic signed [N-1:0] c,
                       input logic signed [N-1:0] m, input logic signed [N-1:0] e);
    exp_t ent;
    exp_t prev;
    @(negedge clk);
    bus.in_valid     = v;
    bus.Constantes_G = c;
    bus.Multip_G     = m;
    bus.Entrada_G    = e;
    @(posedge clk);
    ent.v   = v;
    ent.val = v ? model(longint'(c), longint'(m), longint'(e)) : '0;
    hist.push_back(ent);
    #1;
    prev = hist[hist.size()-2];
    if (prev.v) hold = prev.val;
    chk("out_valid", {{(N-1){1'b0}}, bus.out_valid}, {{(N-1){1'b0}}, prev.v});
    chk("Valores", bus.Valores, hold);
    if (hist.size() > 4) void'(hist.pop_front());
  endtask

  function automatic logic signed [N-1:0] rnd_op(input int mode);
    logic signed [N-1:0] r;
    case (mode)
      0:       r = N'($urandom);
      1:       r = N'($signed($urandom_range(0, 8191)) - 4096);
      default: r = N'($signed($urandom_range(0, 1 << 21)) - (1 << 20));
    endcase
    return r;
  endfunction

  initial begin
    logic signed [N-1:0] c, m, e;
    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.Constantes_G = '0;
    bus.Multip_G     = '0;
    bus.Entrada_G    = '0;
    #2;
    chk("reset_out_valid", {{(N-1){1'b0}}, bus.out_valid}, '0);
    chk("reset_Valores", bus.Valores, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // Directed vectors with fixed expected results
    cycle(1'b1, 25'sd2048, 25'sd1536, 25'sd256);
    cycle(1'b0, '0, '0, '0);
    chk("q_3p25", bus.Valores, 25'd3328);
    cycle(1'b1, -25'sd1024, 25'sd512, 25'sd0);
    cycle(1'b0, '0, '0, '0);
    chk("neg_half", bus.Valores, 25'h1FFFE00);
    cycle(1'b1, 25'sd1, 25'sd1, 25'sd0);
    cycle(1'b0, '0, '0, '0);
    chk("floor_pos", bus.Valores, 25'd0);
    cycle(1'b1, -25'sd1, 25'sd1, 25'sd0);
    cycle(1'b0, '0, '0, '0);
    chk("floor_neg", bus.Valores, 25'h1FFFFFF);
    cycle(1'b1, 25'sd4096, 25'sd4194304, 25'sd0);
    cycle(1'b0, '0, '0, '0);
`ifdef ARITMETICA_SAT_EN
    chk("overflow", bus.Valores, 25'd16777215);
`else
    chk("overflow", bus.Valores, 25'h1000000);
`endif
    cycle(1'b0, 25'sd77, 25'sd99, 25'sd5);
    chk("hold_idle", bus.Valores, 25'h1000000 ^ 25'h1000000 ^ hold);

    // Back-to-back random traffic
    for (int i = 0; i < 5000; i++) begin
      c = rnd_op($urandom_range(0, 2));
      m = rnd_op($urandom_range(0, 2));
      e = rnd_op($urandom_range(0, 2));
      cycle(1'b1, c, m, e);
    end
    for (int i = 0; i < 400; i++) begin
      c = rnd_op($urandom_range(0, 2));
      m = rnd_op($urandom_range(0, 2));
      e = rnd_op($urandom_range(0, 2));
      cycle(1'($urandom_range(0, 1)), c, m, e);
    end

    // Reset with two operations in flight
    cycle(1'b1, 25'sd3000, 25'sd2000, 25'sd17);
    cycle(1'b1, 25'sd1024, 25'sd1024, 25'sd1);
    cycle(1'b1, -25'sd4000, 25'sd700, 25'sd9);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {{(N-1){1'b0}}, bus.out_valid}, '0);
    chk("async_rst_Valores", bus.Valores, '0);
    bus.in_valid = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    model_reset();
    repeat (3) cycle(1'b0, 25'sd5, 25'sd5, 25'sd5);
    cycle(1'b1, 25'sd2048, 25'sd1536, 25'sd256);
    cycle(1'b0, '0, '0, '0);
    chk("post_rst_result", bus.Valores, 25'd3328);
    cycle(1'b0, '0, '0, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
